// File: rtl/axi_cdc_chan_src.sv
// Writer half of a token-based dual-clock AXI channel crossing: local payload buffer,
// Johnson-coded write token out, Johnson read token in (synchronised for flow control).
module axi_cdc_chan_src #(
    parameter int DATA_WIDTH   = 32,
    parameter int BUFFER_WIDTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          valid_i,
    input  logic [DATA_WIDTH-1:0]         data_i,
    output logic                          ready_o,
    output logic [BUFFER_WIDTH-1:0]       writetoken_o,
    input  logic [BUFFER_WIDTH-1:0]       readpointer_i,
    output logic [DATA_WIDTH-1:0]         data_o,
    output logic [$clog2(BUFFER_WIDTH):0] fill_o
);

    localparam int BW = BUFFER_WIDTH;
    localparam int IW = (BW > 1) ? $clog2(BW) : 1;
    localparam int KW = $clog2(2 * BW) + 1;
    localparam logic [KW-1:0] TWO_BW = KW'(2 * BW);
    localparam logic [KW-1:0] BW_K   = KW'(BW);

    // Johnson token -> state number k in 0..2BW-1.
    function automatic logic [KW-1:0] tok_state(input logic [BW-1:0] t);
        logic [KW-1:0] ones;
        ones = '0;
        for (int i = 0; i < BW; i++) begin
            ones = ones + {{(KW-1){1'b0}}, t[i]};
        end
        return t[BW-1] ? (TWO_BW - ones) : ones;
    endfunction

    function automatic logic [IW-1:0] tok_slot(input logic [BW-1:0] t);
        logic [KW-1:0] k;
        k = tok_state(t);
        if (k >= BW_K) begin
            k = k - BW_K;
        end
        return k[IW-1:0];
    endfunction

    logic [BW-1:0]         wt_q;
    logic [BW-1:0]         wt_d;
    logic [BW-1:0]         rp_meta_q;
    logic [BW-1:0]         rps_q;
    logic [DATA_WIDTH-1:0] mem_q [BW];

    logic                  full;
    logic                  push;
    logic [IW-1:0]         wr_slot;
    logic [BW-1:0]         slot_we;
    logic [KW-1:0]         k_wr;
    logic [KW-1:0]         k_rd;
    logic [KW-1:0]         fill_k;

    assign full    = (wt_q == ~rps_q);
    assign push    = valid_i && !full;
    assign wr_slot = tok_slot(wt_q);

    genvar gi;
    generate
        for (gi = 0; gi < BW; gi++) begin : g_slot_we
            assign slot_we[gi] = push && (wr_slot == IW'(gi));
        end
    endgenerate

    always_comb begin
        wt_d = wt_q;
        if (push) begin
            wt_d = {wt_q[BW-2:0], ~wt_q[BW-1]};
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wt_q      <= '0;
            rp_meta_q <= '0;
            rps_q     <= '0;
        end else begin
            wt_q      <= wt_d;
            rp_meta_q <= readpointer_i;
            rps_q     <= rp_meta_q;
        end
    end

    // Slots are cleared on reset so data_o reads zero until written.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < BW; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < BW; i++) begin
                if (slot_we[i]) begin
                    mem_q[i] <= data_i;
                end
            end
        end
    end

    assign k_wr   = tok_state(wt_q);
    assign k_rd   = tok_state(rps_q);
    assign fill_k = (k_wr >= k_rd) ? (k_wr - k_rd) : (k_wr + TWO_BW - k_rd);

    assign ready_o      = !full;
    assign writetoken_o = wt_q;
    assign fill_o       = fill_k[IW:0];
    // Raw readpointer_i on purpose: the reader only points at slots the writer has settled.
    assign data_o       = mem_q[tok_slot(readpointer_i)];

endmodule

// File: tb/tb_axi_cdc_chan_src.sv
// Bench for axi_cdc_chan_src: constant vector table for fill/drain, directed reset and
// wrap sequences, and randomized traffic against a state-number/queue reference model.
module tb_axi_cdc_chan_src;

    localparam int BW = 8;
    localparam int DW = 32;
    localparam int FW = 4;

    logic          clk = 1'b0;
    logic          rstn_i;
    logic          valid_i;
    logic [DW-1:0] data_i;
    logic          ready_o;
    logic [BW-1:0] writetoken_o;
    logic [BW-1:0] readpointer_i;
    logic [DW-1:0] data_o;
    logic [FW-1:0] fill_o;

    always #5 clk = ~clk;

    axi_cdc_chan_src #(.DATA_WIDTH(DW), .BUFFER_WIDTH(BW)) dut (
        .clk_i        (clk),
        .rstn_i       (rstn_i),
        .valid_i      (valid_i),
        .data_i       (data_i),
        .ready_o      (ready_o),
        .writetoken_o (writetoken_o),
        .readpointer_i(readpointer_i),
        .data_o       (data_o),
        .fill_o       (fill_o)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Reference model: writer/reader positions as plain state numbers 0..2BW-1.
    int            mk_w, mk_s1, mk_s2, rk, nwr;
    logic [DW-1:0] mem [BW];
    logic [DW-1:0] q [$];

    function automatic logic [BW-1:0] tok(input int k);
        logic [BW-1:0] t;
        t = '0;
        for (int i = 0; i < BW; i++) t[i] = (k < BW) ? (i < k) : !(i < k - BW);
        return t;
    endfunction

    function automatic int mfill();
        return (mk_w - mk_s2 + 2 * BW) % (2 * BW);
    endfunction

    task automatic model_reset();
        mk_w = 0; mk_s1 = 0; mk_s2 = 0; rk = 0; nwr = 0;
        for (int i = 0; i < BW; i++) mem[i] = '0;
        q.delete();
    endtask

    task automatic tick();
        bit acc;
        @(posedge clk);
        acc = valid_i && (mfill() != BW);
        if (acc) begin
            mem[mk_w % BW] = data_i;
            q.push_back(data_i);
            $display("write #%0d k=%0d slot=%0d data=%08h", nwr + 1, mk_w, mk_w % BW, data_i);
            mk_w = (mk_w + 1) % (2 * BW);
            nwr++;
        end
        mk_s2 = mk_s1;
        mk_s1 = rk;
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_wt"},    writetoken_o, tok(mk_w));
        chk({tag, "_ready"}, ready_o,      mfill() != BW);
        chk({tag, "_fill"},  fill_o,       mfill());
        chk({tag, "_data"},  data_o,       mem[rk % BW]);
    endtask

    task automatic do_reset();
        rstn_i = 1'b0; valid_i = 1'b0; readpointer_i = '0;
        repeat (2) @(negedge clk);
        rstn_i = 1'b1;
        model_reset();
    endtask

    // pv/pr: percent chance of valid and of a reader advance per cycle.
    task automatic run(input string tag, input int cycles, input int pv, input int pr,
                       input bit wrapchk, input int stop_writes);
        int prev;
        for (int c = 0; c < cycles; c++) begin
            valid_i = ($urandom_range(0, 99) < pv);
            data_i  = $urandom;
            prev = nwr;
            tick();
            check_model(tag);
            if (wrapchk && nwr != prev) begin
                if (nwr == 12) chk("wrap_wt_after12", writetoken_o, 8'hF0);
                if (nwr == 16) chk("wrap_wt_after16", writetoken_o, 8'h00);
            end
            if (mk_w != rk && $urandom_range(0, 99) < pr) begin
                chk({tag, "_pop"}, data_o, q.pop_front());
                rk = (rk + 1) % (2 * BW);
                readpointer_i = tok(rk);
            end
            if (stop_writes > 0 && nwr >= stop_writes) break;
        end
        valid_i = 1'b0;
        if (stop_writes > 0) chk({tag, "_write_count"}, nwr, stop_writes);
    endtask

    typedef struct {
        bit            valid;
        logic [DW-1:0] data;
        logic [BW-1:0] rp;
        logic [BW-1:0] wt;
        bit            rdy;
        logic [FW-1:0] fill;
        logic [DW-1:0] dout;
    } vec_t;

    vec_t          vecs [13];
    logic [BW-1:0] wt_seq [8];
    logic [DW-1:0] a [9];

    initial begin
        rstn_i = 1'b1; valid_i = 1'b0; data_i = '0; readpointer_i = '0;
        wt_seq = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
        for (int i = 0; i < 9; i++) a[i] = 32'hA000_0000 + i;
        for (int i = 0; i < 8; i++) vecs[i] = '{1'b1, a[i], 8'h00, wt_seq[i], i < 7, FW'(i + 1), a[0]};
        vecs[8]  = '{1'b1, a[8], 8'h00, 8'hFF, 1'b0, 4'd8, a[0]};
        vecs[9]  = '{1'b1, a[8], 8'h01, 8'hFF, 1'b0, 4'd8, a[1]};
        vecs[10] = '{1'b1, a[8], 8'h01, 8'hFF, 1'b1, 4'd7, a[1]};
        vecs[11] = '{1'b1, a[8], 8'h01, 8'hFE, 1'b0, 4'd8, a[1]};
        vecs[12] = '{1'b0, a[8], 8'h01, 8'hFE, 1'b0, 4'd8, a[1]};

        // Reset state, observed before any clock edge.
        #1 rstn_i = 1'b0;
        #2;
        chk("rst_wt", writetoken_o, 8'h00);
        chk("rst_ready", ready_o, 1'b1);
        chk("rst_fill", fill_o, 4'd0);
        chk("rst_data", data_o, 32'd0);
        do_reset();

        // Fill to full, blocked write, drain release, accept into slot 0.
        for (int i = 0; i < 13; i++) begin
            valid_i = vecs[i].valid; data_i = vecs[i].data; readpointer_i = vecs[i].rp;
            @(posedge clk);
            @(negedge clk);
            $display("vec %0d: valid=%0d rp=%02h -> wt=%02h ready=%0d fill=%0d data=%08h",
                     i, vecs[i].valid, vecs[i].rp, writetoken_o, ready_o, fill_o, data_o);
            chk($sformatf("vec%0d_wt", i),    writetoken_o, vecs[i].wt);
            chk($sformatf("vec%0d_ready", i), ready_o,      vecs[i].rdy);
            chk($sformatf("vec%0d_fill", i),  fill_o,       vecs[i].fill);
            chk($sformatf("vec%0d_data", i),  data_o,       vecs[i].dout);
        end

        // Read mux follows the raw readpointer_i combinationally.
        readpointer_i = 8'h07; #1 chk("mux_07", data_o, a[3]);
        readpointer_i = 8'hF8; #1 chk("mux_F8", data_o, a[3]);
        readpointer_i = 8'hE0; #1 chk("mux_E0", data_o, a[5]);
        readpointer_i = 8'h00; #1 chk("mux_00", data_o, a[8]);

        // Asynchronous reset with five words buffered.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            valid_i = 1'b1; data_i = $urandom;
            tick();
        end
        valid_i = 1'b0;
        check_model("burst");
        chk("burst_fill5", fill_o, 4'd5);
        #2 rstn_i = 1'b0;
        #1;
        $display("async reset mid-burst: wt=%02h fill=%0d ready=%0d", writetoken_o, fill_o, ready_o);
        chk("arst_wt", writetoken_o, 8'h00);
        chk("arst_fill", fill_o, 4'd0);
        chk("arst_ready", ready_o, 1'b1);
        chk("arst_data", data_o, 32'd0);
        @(negedge clk);
        rstn_i = 1'b1;
        model_reset();
        tick();
        chk("arst_ready_after", ready_o, 1'b1);
        check_model("post_arst");

        // Token wrap with a reader keeping up.
        do_reset();
        run("wrap", 200, 100, 100, 1'b1, 20);

        // Randomized traffic: reader slower than writer so full is hit often.
        do_reset();
        run("rand", 300, 80, 30, 1'b0, 0);
        run("rand_drain", 100, 20, 70, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
